sevenseg_scan_controller: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode seven-segment display that shares one sevenseghexdecoder instance between all digits. It presents one nibble at a time on HexVal to the shared decoder and drives the matching active-low anode. It also double-buffers the displayed value so updates only appear at frame boundaries. It sits between user logic, which supplies a packed hex value, and the board display pins.

---
 rtl/sevenseg_scan_controller.sv | 176 +++++++++++++++++
 tb/tb_sevenseg_scan_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan_controller.sv
// sevenseg_scan_controller: time-multiplexed scan of a common-anode
// seven-segment display through one shared hex decoder.
//
// Ports:
//   Clock     system clock, rising edge
//   nReset    async active-low reset
//   Value     packed hex value, digit k = Value[4k+3:4k], digit 0 rightmost
//   Load      one-cycle capture request for Value
//   DigitEn   per-digit enable, 0 keeps that anode off
//   HexVal    registered nibble to the shared decoder
//   Anode     registered active-low anode drive
//   Pending   a captured value waits for the frame boundary
//   FrameDone one-cycle pulse in the last DRIVE cycle of the last digit
//
// Optional: define LEADING_ZERO_BLANK_EN to blank digits above the
// most-significant nonzero nibble (digit 0 always shown).

module sevenseg_scan_controller #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic [4*DIGITS-1:0]   Value,
  input  logic                  Load,
  input  logic [DIGITS-1:0]     DigitEn,
  output logic [3:0]            HexVal,
  output logic [DIGITS-1:0]     Anode,
  output logic                  Pending,
  output logic                  FrameDone
);

  localparam int CMAX =
    (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_n;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_n;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] shadow_n;
  logic [4*DIGITS-1:0] pend_reg;
  logic                blank_end;
  logic                drive_end;
  logic                wrap;
  logic                fd_n;
  logic [DIGITS-1:0]   keep;
  logic [DIGITS-1:0]   drv_pat;

  assign blank_end = (state == BLANK) && (cnt == BLANK_LAST);
  assign drive_end = (state == DRIVE) && (cnt == DRIVE_LAST);
  assign wrap      = drive_end && (idx == IDX_LAST);

  // Next scan position; also used to pre-decode FrameDone so the
  // pulse comes out of a flop yet lands on the wrap cycle itself.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    unique case (state)
      BLANK: begin
        if (blank_end) begin
          state_n = DRIVE;
          cnt_n   = '0;
        end
      end
      DRIVE: begin
        if (drive_end) begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = wrap ? '0 : idx + IW'(1);
        end
      end
      default: begin
        state_n = BLANK;
        cnt_n   = '0;
      end
    endcase
    fd_n = (state_n == DRIVE)
        && (cnt_n == DRIVE_LAST)
        && (idx_n == IDX_LAST);
  end

  // A Load in the wrap cycle bypasses the pending buffer.
  always_comb begin
    shadow_n = shadow;
    if (wrap) begin
      if (Load)
        shadow_n = Value;
      else if (Pending)
        shadow_n = pend_reg;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // keep[i] is set once any nibble at or above i is nonzero.
  always_comb begin
    logic seen;
    seen = 1'b0;
    keep = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen    = seen | (|shadow[4*i +: 4]);
      keep[i] = seen;
    end
    keep[0] = 1'b1;
  end
`else
  assign keep = '1;
`endif

  always_comb begin
    drv_pat = '1;
    if (DigitEn[idx] && keep[idx])
      drv_pat[idx] = 1'b0;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= BLANK;
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      pend_reg  <= '0;
      Pending   <= 1'b0;
      HexVal    <= 4'h0;
      Anode     <= '1;
      FrameDone <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shadow    <= shadow_n;
      FrameDone <= fd_n;

      if (wrap) begin
        if (Load)
          pend_reg <= Value;
        Pending <= 1'b0;
      end else if (Load) begin
        pend_reg <= Value;
        Pending  <= 1'b1;
      end

      unique case (state)
        BLANK: begin
          if (blank_end)
            Anode <= drv_pat;
        end
        DRIVE: begin
          if (drive_end) begin
            Anode  <= '1;
            HexVal <= shadow_n[4*idx_n +: 4];
          end else begin
            Anode <= drv_pat;
          end
        end
        default: Anode <= '1;
      endcase
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_controller.sv
// tb_sevenseg_scan_controller: directed table plus hand-written
// sequences for sevenseg_scan_controller (4 digits, DRIVE 4, BLANK 1).

module tb_sevenseg_scan_controller;

  logic        Clock;
  logic        nReset;
  logic [15:0] Value;
  logic        Load;
  logic [3:0]  DigitEn;
  logic [3:0]  HexVal;
  logic [3:0]  Anode;
  logic        Pending;
  logic        FrameDone;

  int n_cmp;
  int n_bad;

  sevenseg_scan_controller #(
    .DIGITS(4),
    .REFRESH_DIV(4),
    .BLANK_CYC(1)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .Value(Value),
    .Load(Load),
    .DigitEn(DigitEn),
    .HexVal(HexVal),
    .Anode(Anode),
    .Pending(Pending),
    .FrameDone(FrameDone)
  );

  initial begin
    Clock = 1'b1;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic [3:0]  den;
    logic [3:0]  an;
    logic [3:0]  hx;
    logic        pd;
    logic        fd;
  } vec_t;

  localparam int NV = 120;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
               $time);
    end
  endtask

  // Samples one whole frame starting at its first BLANK cycle;
  // optionally issues a Load at frame position 2.
  task automatic check_frame(input logic [15:0] sh,
                             input logic [3:0] lit,
                             input logic ld,
                             input logic [15:0] lv);
    for (int p = 0; p < 20; p++) begin
      int d;
      int ph;
      logic [3:0] ea;
      d  = p / 5;
      ph = p % 5;
      ea = (ph == 0 || !lit[d]) ? 4'hF : ~(4'b0001 << d);
      chk($sformatf("frame_anode p%0d", p), 32'(Anode), 32'(ea));
      chk($sformatf("frame_hex p%0d", p), 32'(HexVal),
          32'(sh[4*d +: 4]));
      chk($sformatf("frame_done p%0d", p), 32'(FrameDone),
          32'(p == 19));
      Load  = ld && (p == 2);
      Value = lv;
      @(negedge Clock);
      #1;
    end
    Load = 1'b0;
  endtask

  initial begin
    logic [15:0] sh [6];
    logic [15:0] s;
    n_cmp = 0;
    n_bad = 0;

    sh[0] = 16'h0000;
    sh[1] = 16'h0000;
    sh[2] = 16'h1A2F;
    sh[3] = 16'hBEEF;
    sh[4] = 16'h0042;
    sh[5] = 16'h0042;

    for (int c = 0; c < NV; c++) begin
      int f;
      int pos;
      int d;
      int ph;
      f   = c / 20;
      pos = c % 20;
      d   = pos / 5;
      ph  = pos % 5;
      tbl[c].ld  = 1'b0;
      tbl[c].val = 16'h0000;
      if (c >= 80 && c < 100)
        tbl[c].den = 4'b0101;
      else if (c >= 102 && c <= 104)
        tbl[c].den = 4'b1110;
      else
        tbl[c].den = 4'hF;
      s = sh[f];
      tbl[c].hx = s[4*d +: 4];
      tbl[c].fd = (pos == 19);
      tbl[c].pd = (c >= 26 && c <= 39) || (c >= 46 && c <= 59)
               || (c >= 111 && c <= 119);
      if (ph == 0)
        tbl[c].an = 4'hF;
      else if (tbl[c-1].den[d])
        tbl[c].an = ~(4'b0001 << d);
      else
        tbl[c].an = 4'hF;
    end
    tbl[25].ld = 1'b1; tbl[25].val = 16'h1A2F;
    tbl[45].ld = 1'b1; tbl[45].val = 16'h1111;
    tbl[50].ld = 1'b1; tbl[50].val = 16'hBEEF;
    tbl[79].ld = 1'b1; tbl[79].val = 16'h0042;
    tbl[110].ld = 1'b1; tbl[110].val = 16'h0300;

    nReset  = 1'b0;
    Load    = 1'b0;
    Value   = 16'h0;
    DigitEn = 4'hF;

    #1;
    chk("rst_anode", 32'(Anode), 32'hF);
    chk("rst_hex", 32'(HexVal), 32'h0);
    chk("rst_pending", 32'(Pending), 32'h0);
    chk("rst_fd", 32'(FrameDone), 32'h0);

    @(negedge Clock);
    #1;
    nReset = 1'b1;

    for (int c = 0; c < NV; c++) begin
      chk($sformatf("anode c%0d", c), 32'(Anode), 32'(tbl[c].an));
      chk($sformatf("hex c%0d", c), 32'(HexVal), 32'(tbl[c].hx));
      chk($sformatf("pending c%0d", c), 32'(Pending), 32'(tbl[c].pd));
      chk($sformatf("framedone c%0d", c), 32'(FrameDone),
          32'(tbl[c].fd));
      Load    = tbl[c].ld;
      Value   = tbl[c].val;
      DigitEn = tbl[c].den;
      @(negedge Clock);
      #1;
    end

    // Frame 6 shows 0300; queue 1234 and reset during digit 2 DRIVE.
    Load  = 1'b1;
    Value = 16'h1234;
    @(negedge Clock);
    #1;
    Load = 1'b0;
    chk("mid_pending_set", 32'(Pending), 32'h1);
    repeat (11) @(negedge Clock);
    #1;
    chk("mid_anode_d2", 32'(Anode), 32'hB);
    chk("mid_hex_d2", 32'(HexVal), 32'h3);
    nReset = 1'b0;
    #1;
    chk("async_anode", 32'(Anode), 32'hF);
    chk("async_hex", 32'(HexVal), 32'h0);
    chk("async_pending", 32'(Pending), 32'h0);
    chk("async_fd", 32'(FrameDone), 32'h0);
    @(negedge Clock);
    #1;
    chk("held_anode", 32'(Anode), 32'hF);
    nReset = 1'b1;

    // Restart at digit 0 with cleared shadow, then leading-zero cases.
    check_frame(16'h0000, 4'hF, 1'b1, 16'h00A0);
`ifdef LEADING_ZERO_BLANK_EN
    check_frame(16'h00A0, 4'b0011, 1'b1, 16'h0000);
    check_frame(16'h0000, 4'b0001, 1'b0, 16'h0000);
`else
    check_frame(16'h00A0, 4'hF, 1'b1, 16'h0000);
    check_frame(16'h0000, 4'hF, 1'b0, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
